// File: rtl/oled_iic_rx_monitor_if.sv
// Decoded byte stream and bus status produced by the SSD1306-side I2C monitor.
// master = the monitor driving the stream, slave = whatever consumes it.
interface oled_iic_rx_monitor_if;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       rx_is_data;
   logic [6:0] rx_col;
   logic [2:0] rx_page;
   logic       bus_start;
   logic       bus_stop;
   logic       rx_err;
   logic       busy;

   modport master (
      output rx_valid, rx_byte, rx_is_data, rx_col, rx_page,
             bus_start, bus_stop, rx_err, busy
   );

   modport slave (
      input  rx_valid, rx_byte, rx_is_data, rx_col, rx_page,
             bus_start, bus_stop, rx_err, busy
   );
endinterface

// File: rtl/oled_iic_rx_monitor.sv
// I2C write-only target emulating the SSD1306: ACKs its address, splits control/payload
// bytes into command and display-data strobes. OLED_RX_PAGE_TRACK_EN adds page/column tracking.
module oled_iic_rx_monitor #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                  clk_50m,
   input  logic                  rst_n,
   input  logic                  iic_scl,
   inout  wire                   iic_sda,
   oled_iic_rx_monitor_if.master rx
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_A, CTRL, ACK_C, PAYLOAD, ACK_P, IGNORE
   } state_t;

   // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_prev, sda_prev;
   logic scl_s, sda_s;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], iic_scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], iic_sda};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   logic start_det, stop_det, rise_det, fall_det;
   assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
   assign rise_det  = scl_s & ~scl_prev;
   assign fall_det  = ~scl_s & scl_prev;

   // Event flags are registered once more; the FSM acts on these.
   logic start_f, stop_f, rise_f, fall_f, sda_r;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         start_f <= 1'b0;
         stop_f  <= 1'b0;
         rise_f  <= 1'b0;
         fall_f  <= 1'b0;
         sda_r   <= 1'b1;
      end else begin
         start_f <= start_det;
         stop_f  <= stop_det;
         rise_f  <= rise_det;
         fall_f  <= fall_det;
         sda_r   <= sda_s;
      end
   end

   state_t     state;
   logic [2:0] bit_cnt;
   logic       bit_rx;
   logic [7:0] shreg;
   logic       co, dc;
   logic       fresh_ctrl;
   logic       sda_oe;

   logic [7:0] byte_in;
   logic       in_byte, in_ack, pay_done;

   assign byte_in  = {shreg[6:0], sda_r};
   assign in_byte  = (state == ADDR) || (state == CTRL) || (state == PAYLOAD);
   assign in_ack   = (state == ACK_A) || (state == ACK_C) || (state == ACK_P);
   assign pay_done = rise_f & ~start_f & ~stop_f & (state == PAYLOAD) & (bit_cnt == 3'd7);

   assign iic_sda = sda_oe ? 1'b0 : 1'bz;

   // bit_cnt counts completed bit periods (advanced on SCL fall after a rise), so the
   // SCL rise that precedes every START/STOP is never mistaken for a received bit.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bit_cnt       <= 3'd0;
         bit_rx        <= 1'b0;
         shreg         <= 8'h00;
         co            <= 1'b0;
         dc            <= 1'b0;
         fresh_ctrl    <= 1'b0;
         sda_oe        <= 1'b0;
         rx.rx_valid   <= 1'b0;
         rx.rx_byte    <= 8'h00;
         rx.rx_is_data <= 1'b0;
         rx.bus_start  <= 1'b0;
         rx.bus_stop   <= 1'b0;
         rx.rx_err     <= 1'b0;
         rx.busy       <= 1'b0;
      end else begin
         rx.rx_valid  <= 1'b0;
         rx.bus_start <= 1'b0;
         rx.bus_stop  <= 1'b0;
         rx.rx_err    <= 1'b0;
         if (start_f) begin
            rx.bus_start <= 1'b1;
            if (in_byte && bit_cnt != 3'd0)
               rx.rx_err <= 1'b1;
            state      <= ADDR;
            bit_cnt    <= 3'd0;
            bit_rx     <= 1'b0;
            sda_oe     <= 1'b0;
            fresh_ctrl <= 1'b0;
         end else if (stop_f) begin
            rx.bus_stop <= 1'b1;
            if ((in_byte && bit_cnt != 3'd0) || (state == ACK_C) ||
                (state == PAYLOAD && fresh_ctrl && bit_cnt == 3'd0))
               rx.rx_err <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            bit_rx     <= 1'b0;
            sda_oe     <= 1'b0;
            fresh_ctrl <= 1'b0;
            rx.busy    <= 1'b0;
         end else if (rise_f) begin
            bit_rx <= 1'b1;
            shreg  <= byte_in;
            if (in_byte && bit_cnt == 3'd7) begin
               case (state)
                  ADDR: begin
                     if (byte_in == {SLAVE_ADDR, 1'b0}) begin
                        state   <= ACK_A;
                        rx.busy <= 1'b1;
                     end else begin
                        state   <= IGNORE;
                        rx.busy <= 1'b0;
                     end
                  end
                  CTRL: begin
                     co    <= byte_in[7];
                     dc    <= byte_in[6];
                     state <= ACK_C;
                  end
                  default: begin
                     rx.rx_valid   <= 1'b1;
                     rx.rx_byte    <= byte_in;
                     rx.rx_is_data <= dc;
                     fresh_ctrl    <= 1'b0;
                     state         <= ACK_P;
                  end
               endcase
            end
         end else if (fall_f) begin
            bit_rx <= 1'b0;
            if (in_byte && bit_rx) begin
               bit_cnt <= bit_cnt + 3'd1;
            end else if (in_ack && bit_rx) begin
               if (!sda_oe) begin
                  // End of bit 8: claim the ACK slot.
                  sda_oe  <= 1'b1;
                  bit_cnt <= 3'd0;
               end else begin
                  sda_oe <= 1'b0;
                  case (state)
                     ACK_A:   state <= CTRL;
                     ACK_C: begin
                        state      <= PAYLOAD;
                        fresh_ctrl <= 1'b1;
                     end
                     default: state <= co ? CTRL : PAYLOAD;
                  endcase
               end
            end
         end
      end
   end

`ifdef OLED_RX_PAGE_TRACK_EN
   logic [6:0] col_ptr;
   logic [2:0] page_ptr;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         col_ptr    <= 7'd0;
         page_ptr   <= 3'd0;
         rx.rx_col  <= 7'd0;
         rx.rx_page <= 3'd0;
      end else if (pay_done) begin
         if (dc) begin
            rx.rx_col  <= col_ptr;
            rx.rx_page <= page_ptr;
            col_ptr    <= col_ptr + 7'd1;
         end else if (byte_in[7:3] == 5'b10110) begin
            page_ptr <= byte_in[2:0];
            col_ptr  <= 7'd0;
         end else if (byte_in[7:4] == 4'h0) begin
            col_ptr[3:0] <= byte_in[3:0];
         end else if (byte_in[7:3] == 5'b00010) begin
            col_ptr[6:4] <= byte_in[2:0];
         end
      end
   end
`else
   assign rx.rx_col  = 7'd0;
   assign rx.rx_page = 3'd0;
`endif

endmodule

// File: tb/tb_oled_iic_rx_monitor.sv
// Directed bench: table of whole I2C write transactions plus hand-written abort/reset/latency cases.
module tb_oled_iic_rx_monitor;
   localparam int S = 2;
   localparam int Q = 12;

   logic clk_50m = 1'b0;
   logic rst_n = 1'b0;
   logic m_scl = 1'b1;
   logic m_sda_low = 1'b0;
   wire  iic_sda;

   assign iic_sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (iic_sda);

   oled_iic_rx_monitor_if rx_if ();

   oled_iic_rx_monitor #(.SLAVE_ADDR(7'h3C), .SYNC_STAGES(S)) dut (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .iic_scl (m_scl),
      .iic_sda (iic_sda),
      .rx      (rx_if)
   );

   always #10 clk_50m = ~clk_50m;

   int checks = 0;
   int failures = 0;

   // Strobe monitor, sampled on the falling clock edge.
   logic       clr = 1'b0;
   int         n_valid, n_start, n_stop, n_err, n_drive;
   logic       busy_seen;
   logic [7:0] got_b [$];
   logic       got_d [$];
   logic [6:0] got_c [$];
   logic [2:0] got_p [$];

   always @(negedge clk_50m) begin
      if (clr) begin
         n_valid = 0; n_start = 0; n_stop = 0; n_err = 0; n_drive = 0;
         busy_seen = 1'b0;
         got_b.delete(); got_d.delete(); got_c.delete(); got_p.delete();
      end else if (rst_n) begin
         if (rx_if.rx_valid) begin
            n_valid++;
            got_b.push_back(rx_if.rx_byte);
            got_d.push_back(rx_if.rx_is_data);
            got_c.push_back(rx_if.rx_col);
            got_p.push_back(rx_if.rx_page);
         end
         if (rx_if.bus_start) n_start++;
         if (rx_if.bus_stop)  n_stop++;
         if (rx_if.rx_err)    n_err++;
         if (!m_sda_low && iic_sda === 1'b0) n_drive++;
         if (rx_if.busy) busy_seen = 1'b1;
      end
   end

   typedef struct {
      string           name;
      int              nb;
      logic [5:0][7:0] b;     // b[0] goes on the wire first
      int              acks;
      int              nv;
      logic [2:0][7:0] eb;
      logic [2:0]      ed;
      logic [2:0][6:0] ecol;
      logic [2:0][2:0] epg;
      logic            busy;
   } vec_t;

   vec_t vt [5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(posedge clk_50m);
      #1;
   endtask

   task automatic clear();
      clr = 1'b1;
      @(negedge clk_50m);
      @(posedge clk_50m);
      #1 clr = 1'b0;
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; wq();
      m_scl = 1'b1;     wq();
      m_sda_low = 1'b1; wq();
      m_scl = 1'b0;     wq();
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; wq();
      m_scl = 1'b1;     wq();
      m_sda_low = 1'b0; wq(); wq();
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         m_sda_low = ~b[i]; wq();
         m_scl = 1'b1;      wq(); wq();
         m_scl = 1'b0;      wq();
      end
   endtask

   task automatic get_ack(output logic ack);
      m_sda_low = 1'b0; wq();
      m_scl = 1'b1;     wq();
      ack = (iic_sda === 1'b0);
      wq();
      m_scl = 1'b0;     wq();
   endtask

   task automatic run_vec(input int k);
      logic a;
      int   na;
      clear();
      na = 0;
      i2c_start();
      for (int j = 0; j < vt[k].nb; j++) begin
         send_bits(vt[k].b[j], 8);
         get_ack(a);
         if (a) na++;
      end
      i2c_stop();
      chk({vt[k].name, "_acks"}, na, vt[k].acks);
      chk({vt[k].name, "_nvalid"}, n_valid, vt[k].nv);
      for (int i = 0; i < vt[k].nv && i < n_valid; i++) begin
         chk($sformatf("%s_byte%0d", vt[k].name, i), int'(got_b[i]), int'(vt[k].eb[i]));
         chk($sformatf("%s_isdata%0d", vt[k].name, i), int'(got_d[i]), int'(vt[k].ed[i]));
         if (vt[k].ed[i]) begin
            chk($sformatf("%s_col%0d", vt[k].name, i), int'(got_c[i]), int'(vt[k].ecol[i]));
            chk($sformatf("%s_page%0d", vt[k].name, i), int'(got_p[i]), int'(vt[k].epg[i]));
         end
      end
      chk({vt[k].name, "_nstart"}, n_start, 1);
      chk({vt[k].name, "_nstop"}, n_stop, 1);
      chk({vt[k].name, "_nerr"}, n_err, 0);
      chk({vt[k].name, "_busy_seen"}, int'(busy_seen), int'(vt[k].busy));
      chk({vt[k].name, "_sda_driven"}, int'(n_drive > 0), int'(vt[k].acks > 0));
      chk({vt[k].name, "_busy_after_stop"}, int'(rx_if.busy), 0);
      chk({vt[k].name, "_sda_released"}, int'(iic_sda === 1'b1), 1);
   endtask

   initial begin
      logic a;
      int   lat;

      vt[0] = '{name: "single_write", nb: 3, b: {8'h00, 8'h00, 8'h00, 8'hAE, 8'h00, 8'h78},
                acks: 3, nv: 1, eb: {8'h00, 8'h00, 8'hAE}, ed: 3'b000,
                ecol: '0, epg: '0, busy: 1'b1};
      vt[1] = '{name: "wrong_addr", nb: 4, b: {8'h00, 8'h00, 8'h11, 8'hAE, 8'h00, 8'h7A},
                acks: 0, nv: 0, eb: '0, ed: 3'b000, ecol: '0, epg: '0, busy: 1'b0};
      vt[2] = '{name: "read_addr", nb: 4, b: {8'h00, 8'h00, 8'h11, 8'hAE, 8'h00, 8'h79},
                acks: 0, nv: 0, eb: '0, ed: 3'b000, ecol: '0, epg: '0, busy: 1'b0};
      vt[3] = '{name: "data_stream", nb: 5, b: {8'h00, 8'h33, 8'h22, 8'h11, 8'h40, 8'h78},
                acks: 5, nv: 3, eb: {8'h33, 8'h22, 8'h11}, ed: 3'b111,
                ecol: '0, epg: '0, busy: 1'b1};
      vt[4] = '{name: "interleaved", nb: 5, b: {8'h00, 8'h55, 8'hC0, 8'hB2, 8'h80, 8'h78},
                acks: 5, nv: 2, eb: {8'h00, 8'h55, 8'hB2}, ed: 3'b010,
                ecol: '0, epg: '0, busy: 1'b1};
`ifdef OLED_RX_PAGE_TRACK_EN
      vt[3].ecol = {7'd2, 7'd1, 7'd0};
      vt[4].epg  = {3'd0, 3'd2, 3'd0};
`endif

      // Reset state
      repeat (5) @(posedge clk_50m);
      #1;
      chk("reset_strobes", int'({rx_if.rx_valid, rx_if.bus_start, rx_if.bus_stop, rx_if.rx_err}), 0);
      chk("reset_busy", int'(rx_if.busy), 0);
      chk("reset_rx_byte", int'(rx_if.rx_byte), 0);
      chk("reset_is_data_ptr", int'({rx_if.rx_is_data, rx_if.rx_col, rx_if.rx_page}), 0);
      chk("reset_sda_z", int'(iic_sda === 1'b1), 1);
      rst_n = 1'b1;
      wq();

      for (int k = 0; k < 5; k++) run_vec(k);

      // START detection latency from the raw SDA edge
      clear();
      m_sda_low = 1'b0; wq();
      m_scl = 1'b1;     wq();
      m_sda_low = 1'b1;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk_50m);
         #1;
         if (rx_if.bus_start) begin
            lat = k;
            break;
         end
      end
      chk("start_latency", lat, S + 2);
      wq();
      m_scl = 1'b0; wq();
      i2c_stop();
      chk("bare_start_stop_err", n_err, 0);

      // Abort: STOP after 4 bits of a payload byte
      clear();
      i2c_start();
      send_bits(8'h78, 8); get_ack(a);
      send_bits(8'h00, 8); get_ack(a);
      send_bits(8'h22, 4);
      m_scl = 1'b0;
      i2c_stop();
      chk("abort_err", n_err, 1);
      chk("abort_nvalid", n_valid, 0);
      chk("abort_busy", int'(rx_if.busy), 0);
      run_vec(0);

      // Control byte followed directly by STOP
      clear();
      i2c_start();
      send_bits(8'h78, 8); get_ack(a);
      send_bits(8'h80, 8); get_ack(a);
      chk("ctrl_only_ack", int'(a), 1);
      i2c_stop();
      chk("ctrl_only_err", n_err, 1);
      chk("ctrl_only_nvalid", n_valid, 0);

      // Reset while the address ACK holds SDA low
      clear();
      i2c_start();
      send_bits(8'h78, 8);
      m_sda_low = 1'b0; wq();
      m_scl = 1'b1;     wq();
      chk("mid_ack_sda_low", int'(iic_sda === 1'b0), 1);
      chk("mid_ack_busy", int'(rx_if.busy), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_sda_released", int'(iic_sda === 1'b1), 1);
      chk("rst_busy", int'(rx_if.busy), 0);
      chk("rst_strobes", int'({rx_if.rx_valid, rx_if.bus_start, rx_if.bus_stop, rx_if.rx_err}), 0);
      chk("rst_rx_byte", int'(rx_if.rx_byte), 0);
      wq();
      m_scl = 1'b0; wq();
      rst_n = 1'b1; wq();
      i2c_stop();
      run_vec(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
